// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard: in-flight write tracker for the pipelined core.
// Keeps one {valid, dest, load} record per pipeline stage after decode,
// shifts them with the pipeline, and resolves per-operand forwarding
// selects and load-use stalls for the instruction in decode.
// Optional statistics counters: define FWD_SCOREBOARD_STATS_EN.
module fwd_scoreboard #(
  parameter int unsigned STAGES   = 3,
  parameter int unsigned NSRC     = 2,
  parameter int unsigned LOAD_LAT = 1,
  localparam int unsigned SELW    = $clog2(STAGES + 1)
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   advance,
  input  logic                   flush,
  input  logic                   issue_valid,
  input  logic                   issue_wen,
  input  logic                   issue_load,
  input  logic [4:0]             issue_dest,
  input  logic [NSRC*5-1:0]      src_sel,
  output logic [NSRC*SELW-1:0]   fwd_sel,
  output logic                   stall,
  output logic [31:0]            busy_mask,
  output logic [3:0]             occupancy
`ifdef FWD_SCOREBOARD_STATS_EN
  ,
  output logic [31:0]            stall_cycles,
  output logic [31:0]            fwd_count
`endif
);

  // Per-stage entry state; index 0 = EX, STAGES-1 = WB.
  logic [STAGES-1:0]       vld_q, vld_d;
  logic [STAGES-1:0][4:0]  dst_q, dst_d;
  logic [STAGES-1:0]       ld_q,  ld_d;

  logic [4:0]      src_c;
  logic [SELW-1:0] sel_c;
  logic            hz_c;
  logic            iss_ok;
  logic            new_vld;

  // Forward select and load-use detection; scanning oldest to youngest
  // lets the youngest matching writer overwrite older ones.
  always_comb begin
    fwd_sel = '0;
    stall   = 1'b0;
    src_c   = '0;
    sel_c   = '0;
    hz_c    = 1'b0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      src_c = src_sel[5*i +: 5];
      sel_c = '0;
      hz_c  = 1'b0;
      for (int unsigned j = 0; j < STAGES; j++) begin
        if (vld_q[STAGES-1-j] && (dst_q[STAGES-1-j] == src_c) && (src_c != 5'd0)) begin
          sel_c = SELW'(STAGES - j);
          hz_c  = ld_q[STAGES-1-j] && ((STAGES - 1 - j) < LOAD_LAT);
        end
      end
      fwd_sel[SELW*i +: SELW] = sel_c;
      stall = stall | hz_c;
    end
  end

  // Issue gating: flush and stall both block entry into stage 0.
  always_comb begin
    iss_ok  = issue_valid & advance & ~stall & ~flush;
    new_vld = iss_ok & issue_wen & (issue_dest != 5'd0);
  end

  // Next-state shift; flush drops whatever sits in stage 0 this cycle.
  always_comb begin
    vld_d = vld_q;
    dst_d = dst_q;
    ld_d  = ld_q;
    if (advance) begin
      for (int unsigned k = 1; k < STAGES; k++) begin
        vld_d[k] = vld_q[k-1];
        dst_d[k] = dst_q[k-1];
        ld_d[k]  = ld_q[k-1];
      end
      if (flush) vld_d[1] = 1'b0;
      vld_d[0] = new_vld;
      dst_d[0] = issue_dest;
      ld_d[0]  = issue_load;
    end else if (flush) begin
      vld_d[0] = 1'b0;
    end
  end

  // Entry registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      vld_q <= '0;
      dst_q <= '0;
      ld_q  <= '0;
    end else begin
      vld_q <= vld_d;
      dst_q <= dst_d;
      ld_q  <= ld_d;
    end
  end

  // Busy register mask and valid-entry count.
  always_comb begin
    busy_mask = '0;
    occupancy = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      if (vld_q[k]) busy_mask[dst_q[k]] = 1'b1;
      occupancy = occupancy + 4'(vld_q[k]);
    end
  end

`ifdef FWD_SCOREBOARD_STATS_EN
  logic [31:0] sc_q, fc_q;
  logic [31:0] nfwd_c;
  logic [32:0] fc_sum_c;

  // Operands forwarded on an accepted issue this cycle.
  always_comb begin
    nfwd_c = '0;
    if (iss_ok) begin
      for (int unsigned i = 0; i < NSRC; i++) begin
        if (fwd_sel[SELW*i +: SELW] != '0) nfwd_c = nfwd_c + 32'd1;
      end
    end
    fc_sum_c = {1'b0, fc_q} + {1'b0, nfwd_c};
  end

  // Saturating statistics counters.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sc_q <= '0;
      fc_q <= '0;
    end else begin
      if (stall && (sc_q != '1)) sc_q <= sc_q + 32'd1;
      fc_q <= fc_sum_c[32] ? '1 : fc_sum_c[31:0];
    end
  end

  assign stall_cycles = sc_q;
  assign fwd_count    = fc_q;
`endif

endmodule

// File: doc/fwd_scoreboard.md
# fwd_scoreboard

Parametrised in-flight write tracker for the pipelined core. It records the destination register of every instruction that has left decode, shifts those records down a configurable number of stages in lockstep with the pipeline, and resolves per-operand forwarding selects and load-use stalls for the instruction currently in decode. It replaces the fixed three-stage forwarding and load-use hazard logic, and supports arbitrary pipeline depth, multiple source operands and configurable load latency.

## Interface
- STAGES, 3, number of tracked stages after decode (stage 0 = EX, STAGES-1 = WB); legal 2..8
- NSRC, 2, number of decode source operands checked
- LOAD_LAT, 1, first stage index at which load data is forwardable; 1 ≤ LOAD_LAT < STAGES
- SELW, $clog2(STAGES+1), derived local width of one forward select
- CLK  in  1  clock, rising edge
- RST  in  1  reset, asynchronous, active-high
- advance  in  1  pipeline moves this cycle (ihit/dhit-qualified enable)
- flush  in  1  squash decode and stage-0 instructions (taken branch/jump)
- issue_valid  in  1  instruction in decode wants to enter stage 0
- issue_wen  in  1  that instruction writes a register
- issue_load  in  1  that instruction is a load
- issue_dest  in  5  its destination register
- src_sel  in  NSRC*5  decode source registers, operand i at [5i+4:5i]
- fwd_sel  out  NSRC*SELW  per operand: 0 = register file, k = forward from stage k-1
- stall  out  1  load-use hazard; hold PC and IF/ID, bubble ID/EX
- busy_mask  out  32  bit r set when any valid entry targets register r
- occupancy  out  4  count of valid entries

## Operation
- Entry per stage: valid, dest[4:0], load. An entry is valid only if issued with issue_wen=1 and dest≠0.
- Match for operand i at stage k: entry valid, dest==src_i, src_i≠0. fwd_sel_i = k+1 for the lowest matching k (youngest writer wins); 0 if none.
- stall = 1 when, for any operand, the youngest match is a load at stage k < LOAD_LAT. fwd_sel for that operand is still driven. The value is don't-care downstream.
- Issue gate: issue is accepted only when issue_valid & advance & ~stall & ~flush. Otherwise stage 0 loads a bubble on an advancing edge.
- Advance=1 edge: stage k+1 ← stage k, stage 0 ← issued entry or bubble, and the stage STAGES-1 entry retires.
- Advance=0 edge: all entries hold.
- Flush=1 edge, with or without advance: the stage-0 entry is discarded.
  - With advance: stage 1 receives a bubble, not the old stage 0.
  - Without advance: stage 0 clears and the other stages hold.
- busy_mask is the OR of one-hot(dest) over valid entries. occupancy is the popcount of valid entries.

## Timing
- fwd_sel and stall are combinational from the registered entries and src_sel; no added latency. Same-cycle src_sel changes take effect immediately.
- Entry state updates on the rising CLK edge only.
- Reset (any time, including mid-stall): all entries invalid. fwd_sel=0, stall=0, busy_mask=0, occupancy=0, and the statistics counters are 0. Outputs settle without waiting for a clock.
- A load issued at edge N stalls a dependent decode during cycles where it sits in stages 0..LOAD_LAT-1 while advancing, i.e. exactly LOAD_LAT stall cycles. Stall cycles extend while advance=0.
- Simultaneous flush and stall: flush wins. Nothing issues, and stall deasserts once stage 0 is cleared.

## Configuration
- FWD_SCOREBOARD_STATS_EN defined: adds outputs stall_cycles (32, out) and fwd_count (32, out).
  - stall_cycles increments every cycle stall=1.
  - fwd_count increments per cycle by the number of operands with fwd_sel≠0 on an accepted issue.
  - Both are saturating, reset to 0 by RST, and hold when saturated.
- Undefined: the ports and counters are absent, and the remaining behaviour is identical.

## Test plan
- Reset mid-run: fill all stages, assert RST without a clock edge → occupancy=0, busy_mask=0, fwd_sel=0 immediately.
- Back-to-back ALU chain: issue dest=8 for three advancing cycles, with src_sel op0=8 → fwd_sel0=1 (closest match), and busy_mask=0x100 until the last entry retires.
- Load-use, LOAD_LAT=1: issue a load with dest=9, next decode src=9 → stall=1 for exactly 1 cycle, then fwd_sel=2 with stall=0. With advance=0 held for 3 cycles, stall stays 1 throughout.
- Register 0: issue dest=0 with wen=1, decode src=0 → fwd_sel=0, busy_mask bit 0 never set, occupancy unchanged.
- Flush: stage 0 holds dest=5 and a new issue targets dest=6; assert flush with advance → next cycle busy_mask bits 5 and 6 clear, stage 1 is a bubble, stall=0.
- Stats (macro on, STAGES=4): 2-cycle load-use stall with LOAD_LAT=2 → stall_cycles=2. The issue then forwards both operands → fwd_count=2.
